// File: rtl/hex_tx_pkg.sv
// Shared types and constants for the hex word transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hex_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEX  = 2'd1,
        CR   = 2'd2,
        LF   = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/dec2assic.sv
// Converts one 4-bit nibble to its uppercase ASCII hex character.
// Latency: combinational.
// Backpressure: none; pure function of the input.
module dec2assic (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // 0-9 land on '0'..'9'; 10-15 land on 'A'..'F' ('A' - 10 = 0x37)
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/hex_word_tx.sv
// Prints a DATA_W-bit word as ASCII hex (MS nibble first), optionally followed by CR LF.
// Latency: first character valid 1 cycle after the input handshake; one character per tx handshake, no bubbles.
// Backpressure: tx_data/tx_valid held while tx_ready is low; in_ready is high only while idle.
module hex_word_tx
    import hex_tx_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter bit CRLF_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int NIBBLES = DATA_W / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t              state;
    logic [DATA_W-1:0]   word_reg;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [3:0]          nibble;
    logic [7:0]          ascii;

    // Pick the nibble for the character being loaded next: the top nibble of
    // the incoming word when idle, otherwise the next lower latched nibble.
    always_comb begin
        cnt_next = cnt - CNT_W'(1);
        if (state == IDLE) begin
            nibble = in_data[DATA_W-1 -: 4];
        end else begin
            nibble = word_reg[{cnt_next, 2'b00} +: 4];
        end
    end

    dec2assic u_dec2assic (
        .nibble (nibble),
        .ascii  (ascii)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Main sequencer: latch word, then walk nibbles and optional CR LF, one per handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_reg <= '0;
            cnt      <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_reg <= in_data;
                        cnt      <= CNT_W'(NIBBLES - 1);
                        tx_data  <= ascii;
                        tx_valid <= 1'b1;
                        state    <= HEX;
                    end
                end
                HEX: begin
                    if (tx_valid && tx_ready) begin
                        if (cnt != '0) begin
                            cnt     <= cnt_next;
                            tx_data <= ascii;
                        end else if (CRLF_EN) begin
                            tx_data <= ASCII_CR;
                            state   <= CR;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                CR: begin
                    if (tx_valid && tx_ready) begin
                        tx_data <= ASCII_LF;
                        state   <= LF;
                    end
                end
                LF: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_tx.sv
// Self-checking bench for hex_word_tx: 16-bit/CRLF instance and 8-bit/no-CRLF instance.
// Latency: n/a.
// Backpressure: exercised via directed and random tx_ready stalls.
module tb_hex_word_tx;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: DATA_W=16, CRLF_EN=1
    logic [15:0] a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_tx_data;
    logic        a_tx_valid;
    logic        a_tx_ready;
    logic        a_busy;

    // Instance B: DATA_W=8, CRLF_EN=0
    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid;
    logic        b_tx_ready;
    logic        b_busy;

    hex_word_tx #(.DATA_W(16), .CRLF_EN(1'b1)) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (a_in_data),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .tx_data  (a_tx_data),
        .tx_valid (a_tx_valid),
        .tx_ready (a_tx_ready),
        .busy     (a_busy)
    );

    hex_word_tx #(.DATA_W(8), .CRLF_EN(1'b0)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (b_in_data),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .tx_data  (b_tx_data),
        .tx_valid (b_tx_valid),
        .tx_ready (b_tx_ready),
        .busy     (b_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [47:0] exp;       // six expected characters, first in the top byte
        int          stall_idx; // character index to hold tx_ready low at (-1 = none)
        int          stall_len;
        bit          nv;        // keep in_valid high with nw after acceptance
        logic [15:0] nw;
    } vec_t;

    vec_t vecs[5];

    // Model: uppercase hex character of a nibble
    function automatic logic [7:0] hexchar(input logic [3:0] n);
        logic [7:0] digits [16];
        digits = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                   8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return digits[n];
    endfunction

    function automatic logic [47:0] exp_line(input logic [15:0] w);
        return {hexchar(w[15:12]), hexchar(w[11:8]), hexchar(w[7:4]), hexchar(w[3:0]), 8'h0D, 8'h0A};
    endfunction

    // One word on instance A; starts idle before a negedge, ends just after the last handshake edge
    task automatic run_a(input logic [15:0] w, input logic [47:0] exp, input int stall_idx,
                         input int stall_len, input bit nv, input logic [15:0] nw);
        @(negedge clk);
        check("a_idle_in_ready", a_in_ready, 1);
        check("a_idle_tx_valid", a_tx_valid, 0);
        check("a_idle_busy", a_busy, 0);
        a_in_data  = w;
        a_in_valid = 1'b1;
        a_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = nv;
        a_in_data  = nv ? nw : 16'h5555;
        for (int k = 0; k < 6; k++) begin
            if (k == stall_idx) begin
                a_tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("a_stall_valid", a_tx_valid, 1);
                    check("a_stall_data", a_tx_data, exp[47-8*k -: 8]);
                    check("a_stall_in_ready", a_in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                a_tx_ready = 1'b1;
            end
            @(negedge clk);
            check("a_char_valid", a_tx_valid, 1);
            check("a_char_data", a_tx_data, exp[47-8*k -: 8]);
            check("a_char_busy", a_busy, 1);
            check("a_char_in_ready", a_in_ready, 0);
            @(posedge clk);
            #1;
        end
    endtask

    // One word on instance B (two characters, never CR/LF)
    task automatic run_b(input logic [7:0] w, input logic [15:0] exp, input bit nv, input logic [7:0] nw);
        @(negedge clk);
        check("b_idle_in_ready", b_in_ready, 1);
        check("b_idle_tx_valid", b_tx_valid, 0);
        check("b_idle_busy", b_busy, 0);
        b_in_data  = w;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = nv;
        b_in_data  = nv ? nw : 8'hAA;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("b_char_valid", b_tx_valid, 1);
            check("b_char_data", b_tx_data, exp[15-8*k -: 8]);
            check("b_char_busy", b_busy, 1);
            @(posedge clk);
            #1;
        end
    endtask

    // Random word on instance A with random tx_ready stalls, checked against the model
    task automatic run_rand(input logic [15:0] w);
        logic [47:0] exp;
        logic [7:0]  held;
        bit          stalled;
        int          k;
        int          cyc;
        exp     = exp_line(w);
        stalled = 1'b0;
        held    = 8'h00;
        k       = 0;
        cyc     = 0;
        @(negedge clk);
        check("r_idle_in_ready", a_in_ready, 1);
        a_in_data  = w;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = 16'($urandom);
        while (k < 6 && cyc < 200) begin
            a_tx_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("r_valid", a_tx_valid, 1);
            if (stalled) check("r_stable", a_tx_data, held);
            if (a_tx_ready) begin
                check("r_char", a_tx_data, exp[47-8*k -: 8]);
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = a_tx_data;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (k < 6) check("r_timeout_chars", k, 6);
        a_tx_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1A2F, 48'h3141_3246_0D0A, -1, 0, 1'b0, 16'h0000};
        vecs[1] = '{16'h00F9, 48'h3030_4639_0D0A,  1, 5, 1'b0, 16'h0000};
        vecs[2] = '{16'hBEEF, 48'h4245_4546_0D0A,  3, 2, 1'b1, 16'h1234};
        vecs[3] = '{16'h1234, 48'h3132_3334_0D0A, -1, 0, 1'b0, 16'h0000};
        vecs[4] = '{16'h9D70, 48'h3944_3730_0D0A,  5, 3, 1'b0, 16'h0000};

        rst_n      = 1'b0;
        a_in_data  = 16'h0;
        a_in_valid = 1'b0;
        a_tx_ready = 1'b1;
        b_in_data  = 8'h0;
        b_in_valid = 1'b0;
        b_tx_ready = 1'b1;
        #1;
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_a_tx_valid", a_tx_valid, 0);
        check("rst_a_tx_data", a_tx_data, 8'h00);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_tx_valid", b_tx_valid, 0);
        check("rst_b_busy", b_busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table on instance A
        for (int i = 0; i < 5; i++) begin
            run_a(vecs[i].word, vecs[i].exp, vecs[i].stall_idx, vecs[i].stall_len, vecs[i].nv, vecs[i].nw);
        end

        // Instance B: 8'hFF then 8'h05 held back-to-back
        run_b(8'hFF, 16'h4646, 1'b1, 8'h05);
        run_b(8'h05, 16'h3035, 1'b0, 8'h00);
        @(negedge clk);
        check("b_end_tx_valid", b_tx_valid, 0);
        check("b_end_in_ready", b_in_ready, 1);

        // Reset in the middle of 16'hCAFE, during its third character
        a_in_data  = 16'hCAFE;
        a_in_valid = 1'b1;
        a_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_third_char", a_tx_data, 8'h46);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", a_tx_valid, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_tx_data", a_tx_data, 8'h00);
        check("mid_rst_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_a(16'h0001, 48'h3030_3031_0D0A, -1, 0, 1'b0, 16'h0000);

        // Random words with random stalls
        for (int i = 0; i < 1000; i++) begin
            run_rand(16'($urandom));
        end
        @(negedge clk);
        check("final_idle_tx_valid", a_tx_valid, 0);
        check("final_idle_in_ready", a_in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
